// File: rtl/uart_note_tx.sv
// Note-index UART transmitter: FIFO-buffered 6-bit notes sent as 8N1 frames, LSB first.
// Define UART_NOTE_PARITY_EN to insert an even-parity bit (8E1).
module uart_note_tx #(
  parameter int CLKS_PER_BIT = 604,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [5:0]                    note_in,
  input  logic                          note_valid_in,
  input  logic                          clear_in,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_NOTE_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state;
  logic [5:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
`ifdef UART_NOTE_PARITY_EN
  logic           par;
`endif

  logic pop, full, push_ok, bit_end;
  logic [5:0] head;

  assign pop     = (state == IDLE) && (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = note_valid_in && (!full || pop);
  assign head    = mem[rd_ptr];
  assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign fifo_count_out = count;

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= note_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (clear_in)                    overflow_out <= 1'b0;
      else if (note_valid_in && !push_ok) overflow_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_out   <= 1'b1;
      busy_out <= 1'b0;
`ifdef UART_NOTE_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_out   <= 1'b1;
          busy_out <= 1'b0;
          if (pop) begin
            shift    <= {2'b00, head};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= 1'b0;
            busy_out <= 1'b1;
            state    <= START;
`ifdef UART_NOTE_PARITY_EN
            par      <= ^head;
`endif
          end
        end
        START: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
          if (bit_end) begin
            tx_out <= shift[0];
            state  <= DATA;
          end
        end
        DATA: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
          if (bit_end) begin
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_NOTE_PARITY_EN
              tx_out <= par;
              state  <= PARITY;
`else
              tx_out <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              tx_out <= shift[1];
            end
          end
        end
`ifdef UART_NOTE_PARITY_EN
        PARITY: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
          if (bit_end) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
          if (bit_end) begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_out   <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_note_tx.sv
// Bench for uart_note_tx: directed scenarios plus random pushes against a frame-timeline model.
module tb_uart_note_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_NOTE_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME   = NB * CPB;
  localparam int CPB_DEF = 604;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [5:0] note_in = '0;
  logic       note_valid_in = 1'b0;
  logic       clear_in = 1'b0;
  logic       tx_out, busy_out, overflow_out;
  logic [2:0] fifo_count_out;

  logic [5:0] note_def = '0;
  logic       valid_def = 1'b0;
  logic       clear_def = 1'b0;
  logic       tx_def, busy_def, ov_def;
  logic [3:0] cnt_def;

  int n_checks = 0;
  int n_fail   = 0;

  uart_note_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .note_in(note_in), .note_valid_in(note_valid_in),
    .clear_in(clear_in), .tx_out(tx_out), .busy_out(busy_out),
    .fifo_count_out(fifo_count_out), .overflow_out(overflow_out));

  uart_note_tx dut_def (
    .clk_in(clk_in), .rst_in(rst_in), .note_in(note_def), .note_valid_in(valid_def),
    .clear_in(clear_def), .tx_out(tx_def), .busy_out(busy_def),
    .fifo_count_out(cnt_def), .overflow_out(ov_def));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a queue of pending notes and the timeline of the frame on the line.
  int         cyc = 0;
  logic [5:0] mq[$];
  int         start = -1;
  logic       fb[NB];
  logic       m_ov = 1'b0;

  always @(posedge clk_in) begin : model
    logic       pop, dropped;
    logic [5:0] n;
    logic [7:0] b;
    if (rst_in) begin
      mq.delete();
      start = -1;
      m_ov  = 1'b0;
    end else begin
      pop     = ((start < 0) || (cyc >= start + FRAME)) && (mq.size() > 0);
      dropped = note_valid_in && (mq.size() == DEPTH) && !pop;
      if (pop) begin
        n = mq.pop_front();
        b = {2'b00, n};
        start = cyc + 1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef UART_NOTE_PARITY_EN
        fb[9]  = ^b;
        fb[10] = 1'b1;
`else
        fb[9]  = 1'b1;
`endif
      end
      if (note_valid_in && !dropped) mq.push_back(note_in);
      if (clear_in)     m_ov = 1'b0;
      else if (dropped) m_ov = 1'b1;
    end
    cyc++;
  end

  bit   chk_en = 1'b0;
  int   rises[$];
  logic busy_q = 1'b0;

  always @(negedge clk_in) begin : monitor
    logic act;
    logic exp_tx;
    if (chk_en) begin
      if (rst_in) begin
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_ovf", overflow_out, 0);
      end else begin
        act    = (start >= 0) && (cyc >= start) && (cyc < start + FRAME);
        exp_tx = act ? fb[(cyc - start) / CPB] : 1'b1;
        chk("tx", tx_out, exp_tx);
        chk("busy", busy_out, act);
        chk("count", fifo_count_out, mq.size());
        chk("ovf", overflow_out, m_ov);
      end
    end
    if (busy_out === 1'b1 && busy_q === 1'b0) rises.push_back(cyc);
    busy_q = busy_out;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [5:0] n);
    note_in       = n;
    note_valid_in = 1'b1;
    step();
    note_valid_in = 1'b0;
  endtask

  initial begin
    int p, lat, fall, low_run, busy_n;
    bit in_start;
    logic [NB-1:0] rx;

    repeat (3) step();
    chk("reset_tx", tx_out, 1);
    chk("reset_busy", busy_out, 0);
    chk("reset_count", fifo_count_out, 0);
    chk("reset_ovf", overflow_out, 0);
    rst_in = 1'b0;
    chk_en = 1'b1;
    repeat (2) step();

    // single note: start bit from cycle 2, busy falls after the full frame
    p = cyc;
    push(6'h2A);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (tx_out === 1'b0) begin lat = cyc - p; break; end
    end
    chk("single_latency", lat, 2);
    fall = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_in);
      if (busy_out === 1'b0) begin fall = cyc - p; break; end
    end
    chk("single_busy_fall", fall, 2 + FRAME);
    step();
    repeat (5) step();

    // burst of five: back-to-back frames, no overflow
    rises.delete();
    for (int v = 1; v <= 5; v++) push(6'(v));
    repeat (6 * (FRAME + 1)) step();
    chk("burst_frames", rises.size(), 5);
    for (int i = 1; i < rises.size(); i++) chk("burst_gap", rises[i] - rises[i-1], FRAME + 1);
    chk("burst_ovf", overflow_out, 0);

    // overflow: sixth push dropped, clear pulse resets the flag
    rises.delete();
    for (int v = 0; v < 6; v++) push(6'(8'h10 + v));
    step();
    chk("ovf_set", overflow_out, 1);
    repeat (6 * (FRAME + 1)) step();
    chk("ovf_frames", rises.size(), 5);
    chk("ovf_held", overflow_out, 1);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("ovf_clear", overflow_out, 0);
    repeat (3) step();

    // reset during data bit 3 (note bit 3 is 0 so the line is low beforehand)
    p = cyc;
    push(6'h21);
    push(6'h11);
    while (cyc < p + 2 + CPB + 3 * CPB + 1) step();
    chk("rstmid_pre_tx", tx_out, 0);
    chk("rstmid_pre_count", fifo_count_out, 1);
    #1 rst_in = 1'b1;
    #1;
    chk("rstmid_tx", tx_out, 1);
    chk("rstmid_count", fifo_count_out, 0);
    chk("rstmid_busy", busy_out, 0);
    step();
    step();
    rst_in = 1'b0;
    repeat (30) step();
    chk("rstmid_idle_tx", tx_out, 1);
    chk("rstmid_idle_busy", busy_out, 0);

    // parity-relevant notes
    push(6'h07);
    push(6'h03);
    repeat (3 * (FRAME + 1)) step();

    // random traffic
    repeat (2500) begin
      note_in       = 6'($urandom);
      note_valid_in = ($urandom_range(0, 5) == 0);
      clear_in      = ($urandom_range(0, 40) == 0);
      step();
    end
    note_valid_in = 1'b0;
    clear_in      = 1'b0;
    repeat ((DEPTH + 1) * (FRAME + 1) + 20) step();
    chk("drain_count", fifo_count_out, 0);

    // default parameters: one note, measured at mid-bit
    note_def  = 6'h15;
    valid_def = 1'b1;
    step();
    valid_def = 1'b0;
    low_run  = 0;
    busy_n   = 0;
    in_start = 1'b1;
    rx       = '0;
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk_in);
      if (busy_def === 1'b1) begin
        busy_n++;
        if (in_start) begin
          if (tx_def === 1'b0) low_run++;
          else in_start = 1'b0;
        end
        for (int b = 0; b < NB; b++)
          if (busy_n == b * CPB_DEF + CPB_DEF / 2) rx[b] = tx_def;
      end else if (busy_n > 0) begin
        break;
      end
    end
    chk("def_start_len", low_run, CPB_DEF);
    chk("def_frame_len", busy_n, NB * CPB_DEF);
    chk("def_data", rx[8:1], 8'h15);
    chk("def_stop", rx[NB-1], 1);
`ifdef UART_NOTE_PARITY_EN
    chk("def_parity", rx[9], 1);
`endif
    chk("def_count", cnt_def, 0);
    chk("def_ovf", ov_def, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
